// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Gray-code helpers and default sizing for the dual-clock FIFO
package fifo_pkg;
    localparam int FIFO_DEFAULT_ADDR_W = 6;
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Narrower pointers are zero-extended; leading zeros decode to zeros.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
endpackage

// File: rtl/sync_bus.sv
// rtl/sync_bus.sv - multi-flop synchroniser for a Gray pointer or a level signal
module sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/async_fifo_param.sv
// rtl/async_fifo_param.sv - dual-clock FIFO, Gray pointer crossing, counts, thresholds, sticky errors
module async_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = FIFO_DEFAULT_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 56,
    parameter int AEMPTY_TH   = 4
) (
    input  logic              rstn,
    input  logic              clk_r,
    input  logic              clk_w,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              wr_afull,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              rd_aempty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow,
    input  logic              err_clr
);
    localparam int PW = ADDR_W + 1;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, rgray_sync, rbin_sync;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, wgray_sync, wbin_sync;
    logic          wr_ok, rd_ok, clr_w, clr_r;

    sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_rptr (
        .clk(clk_w), .rstn(rstn), .d(rgray), .q(rgray_sync));
    sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_wptr (
        .clk(clk_r), .rstn(rstn), .d(wgray), .q(wgray_sync));
    sync_bus #(.WIDTH(1), .STAGES(2)) u_sync_clr_w (
        .clk(clk_w), .rstn(rstn), .d(err_clr), .q(clr_w));
    sync_bus #(.WIDTH(1), .STAGES(2)) u_sync_clr_r (
        .clk(clk_r), .rstn(rstn), .d(err_clr), .q(clr_r));

    assign wr_ok      = wr_en && !full;
    assign wbin_next  = wbin + PW'(wr_ok);
    assign wgray_next = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));

    assign rd_ok      = rd_en && !empty;
    assign rbin_next  = rbin + PW'(rd_ok);
    assign rgray_next = PW'(bin2gray(GRAY_MAX_W'(rbin_next)));

    always_ff @(posedge clk_w) begin
        if (wr_ok) begin
            mem[wbin[ADDR_W-1:0]] <= wr_data;
        end
    end

    // The synchronised pointer is decoded to binary in its own register stage, so counts trail the flags by one edge.
    always_ff @(posedge clk_w or negedge rstn) begin
        if (!rstn) begin
            wbin      <= '0;
            wgray     <= '0;
            rbin_sync <= '0;
            full      <= 1'b0;
            wr_count  <= '0;
            wr_afull  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wgray     <= wgray_next;
            rbin_sync <= PW'(gray2bin(GRAY_MAX_W'(rgray_sync)));
            full      <= (wgray_next == {~rgray_sync[PW-1:PW-2], rgray_sync[PW-3:0]});
            wr_count  <= wbin_next - rbin_sync;
            wr_afull  <= (wr_count >= PW'(AFULL_TH));
            if (clr_w) begin
                overflow <= 1'b0;
            end else if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_r or negedge rstn) begin
        if (!rstn) begin
            rbin      <= '0;
            rgray     <= '0;
            wbin_sync <= '0;
            empty     <= 1'b1;
            rd_count  <= '0;
            rd_aempty <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            underflow <= 1'b0;
        end else begin
            rbin      <= rbin_next;
            rgray     <= rgray_next;
            wbin_sync <= PW'(gray2bin(GRAY_MAX_W'(wgray_sync)));
            empty     <= (rgray_next == wgray_sync);
            rd_count  <= wbin_sync - rbin_next;
            rd_aempty <= (rd_count <= PW'(AEMPTY_TH));
            rd_valid  <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rbin[ADDR_W-1:0]];
            end
            if (clr_r) begin
                underflow <= 1'b0;
            end else if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule
